// File: rtl/led_pattern_writer.sv
// Walks the pattern memory from 0 to DEPTH-1 and emits one LED pattern word per address on a valid/ready write port.
// Optional LED_PATTERN_BOUNCE_EN: LEDs ping-pong (0,1,2,3,2,1) instead of rotating; that build needs ADDR_W >= 3.
module led_pattern_writer #(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 4096,
  parameter int STEP_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  // High nibble walks right while the low nibble walks left, so they mirror each other.
  function automatic logic [7:0] patternFor(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    logic [1:0]        p;
`ifdef LED_PATTERN_BOUNCE_EN
    logic [ADDR_W-1:0] r;
`endif
    s = a >> STEP_SHIFT;
`ifdef LED_PATTERN_BOUNCE_EN
    r = s % ADDR_W'(6);
    p = (r < ADDR_W'(4)) ? r[1:0] : 2'(ADDR_W'(6) - r);
`else
    p = s[1:0];
`endif
    patternFor = {4'b1000 >> p, 4'b0001 << p};
  endfunction

  assign addr_d = addr_q + ADDR_W'(1);

  // The last word is detected by comparing against LastAddr, so DEPTH = 2^ADDR_W never relies on wrap-around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FILL;
            addr_q  <= '0;
            data_q  <= patternFor('0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FILL: begin
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (wr_ready) begin
            if (addr_q == LastAddr) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_d;
              data_q <= patternFor(addr_d);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = valid_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;

endmodule

// File: tb/tb_led_pattern_writer.sv
// Randomized self-checking bench for led_pattern_writer; three instances cover DEPTH=8, a full 2^ADDR_W fill with STEP_SHIFT=1, and DEPTH=1.
// Expected words come from the pattern sequence tables (rotate or LED_PATTERN_BOUNCE_EN ping-pong).
module tb_led_pattern_writer;

  localparam int AW = 4;
  localparam int DA = 8;
  localparam int DB = 16;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          aStart = 0, aAbort = 0, aReady = 0;
  logic          aBusy, aDone, aValid;
  logic [AW-1:0] aAddr;
  logic [7:0]    aData;

  logic          bStart = 0, bAbort = 0, bReady = 0;
  logic          bBusy, bDone, bValid;
  logic [AW-1:0] bAddr;
  logic [7:0]    bData;

  logic          cStart = 0, cAbort = 0, cReady = 0;
  logic          cBusy, cDone, cValid;
  logic [CW-1:0] cAddr;
  logic [7:0]    cData;

  int testsRun = 0;
  int testsFailed = 0;

  led_pattern_writer #(.ADDR_W(AW), .DEPTH(DA), .STEP_SHIFT(0)) dutA (
    .clk(clk), .rst_n(rst_n), .start(aStart), .abort(aAbort), .busy(aBusy), .done(aDone),
    .wr_valid(aValid), .wr_ready(aReady), .wr_addr(aAddr), .wr_data(aData));

  led_pattern_writer #(.ADDR_W(AW), .DEPTH(DB), .STEP_SHIFT(1)) dutB (
    .clk(clk), .rst_n(rst_n), .start(bStart), .abort(bAbort), .busy(bBusy), .done(bDone),
    .wr_valid(bValid), .wr_ready(bReady), .wr_addr(bAddr), .wr_data(bData));

  led_pattern_writer #(.ADDR_W(CW), .DEPTH(1), .STEP_SHIFT(0)) dutC (
    .clk(clk), .rst_n(rst_n), .start(cStart), .abort(cAbort), .busy(cBusy), .done(cDone),
    .wr_valid(cValid), .wr_ready(cReady), .wr_addr(cAddr), .wr_data(cData));

  function automatic logic [7:0] expData(input int addr, input int ss);
    int s;
`ifdef LED_PATTERN_BOUNCE_EN
    logic [7:0] seq[6] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42};
    s = addr >> ss;
    return seq[s % 6];
`else
    logic [7:0] seq[4] = '{8'h81, 8'h42, 8'h24, 8'h18};
    s = addr >> ss;
    return seq[s % 4];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    testsRun++;
    if ({aValid, aBusy, aDone, aAddr, aData} !== 15'h0) begin
      testsFailed++;
      $display("[TB] FAIL resetA: got %h expected %h", {aValid, aBusy, aDone, aAddr, aData}, 15'h0);
    end
    testsRun++;
    if ({bValid, bBusy, bDone, bAddr, bData, cValid, cBusy, cDone, cAddr, cData} !== 29'h0) begin
      testsFailed++;
      $display("[TB] FAIL resetBC: got %h expected %h",
               {bValid, bBusy, bDone, bAddr, bData, cValid, cBusy, cDone, cAddr, cData}, 29'h0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // mode 0: ready always high, 1: three-cycle stall at addr 2, 2: random ready plus start noise while busy
  task automatic runFillA(input int mode, input string name);
    int idx = 0, cycles = 0, transfers = 0, stall = 0, busyCycles = 0;
    logic rdy;
    logic [14:0] expVec;
    aStart = 1'b1;
    tick();
    aStart = 1'b0;
    while (idx < DA && cycles < 200) begin
      expVec = {3'b110, AW'(idx), expData(idx, 0)};
      testsRun++;
      if ({aValid, aBusy, aDone, aAddr, aData} !== expVec) begin
        testsFailed++;
        $display("[TB] FAIL %s word%0d: got %h expected %h", name, idx, {aValid, aBusy, aDone, aAddr, aData}, expVec);
      end
      busyCycles += int'(aBusy);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) begin
        if (idx == 2 && stall < 3) begin rdy = 1'b0; stall++; end
        else rdy = 1'b1;
      end else rdy = ($urandom_range(0, 3) != 0);
      aReady = rdy;
      if (mode == 2) aStart = ($urandom_range(0, 7) == 0);
      tick();
      cycles++;
      if (rdy) begin idx++; transfers++; end
    end
    aReady = 1'b0;
    aStart = 1'b0;
    testsRun++;
    if (cycles >= 200) begin
      testsFailed++;
      $display("[TB] FAIL %s timeout: got %0d cycles expected < 200", name, cycles);
    end
    busyCycles += int'(aBusy);
    testsRun++;
    if ({aValid, aBusy, aDone} !== 3'b011) begin
      testsFailed++;
      $display("[TB] FAIL %s donePulse: got %b expected 011", name, {aValid, aBusy, aDone});
    end
    tick();
    testsRun++;
    if ({aValid, aBusy, aDone} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL %s backToIdle: got %b expected 000", name, {aValid, aBusy, aDone});
    end
    testsRun++;
    if (transfers != DA) begin
      testsFailed++;
      $display("[TB] FAIL %s transfers: got %0d expected %0d", name, transfers, DA);
    end
    if (mode == 0) begin
      testsRun++;
      if (busyCycles != DA + 1 || cycles != DA) begin
        testsFailed++;
        $display("[TB] FAIL %s throughput: got busy %0d cycles %0d expected busy %0d cycles %0d",
                 name, busyCycles, cycles, DA + 1, DA);
      end
    end
    if (mode == 1) begin
      testsRun++;
      if (stall != 3 || cycles != DA + 3) begin
        testsFailed++;
        $display("[TB] FAIL %s stall: got stall %0d cycles %0d expected 3 and %0d", name, stall, cycles, DA + 3);
      end
    end
  endtask

  task automatic test_basic_fill();
    runFillA(0, "basicFill");
  endtask

  task automatic test_backpressure();
    runFillA(1, "backpressure");
  endtask

  task automatic test_random_fill();
    for (int n = 0; n < 4; n++) runFillA(2, "randomFill");
  endtask

  task automatic test_back_to_back();
    runFillA(0, "backToBack1");
    runFillA(0, "backToBack2");
  endtask

  task automatic test_abort();
    logic [14:0] expVec;
    aStart = 1'b1;
    aAbort = 1'b1;
    tick();
    aStart = 1'b0;
    aAbort = 1'b0;
    aReady = 1'b1;
    for (int idx = 0; idx <= 5; idx++) begin
      expVec = {3'b110, AW'(idx), expData(idx, 0)};
      testsRun++;
      if ({aValid, aBusy, aDone, aAddr, aData} !== expVec) begin
        testsFailed++;
        $display("[TB] FAIL abortWalk word%0d: got %h expected %h", idx, {aValid, aBusy, aDone, aAddr, aData}, expVec);
      end
      if (idx == 5) begin aAbort = 1'b1; aStart = 1'b1; end
      tick();
    end
    aAbort = 1'b0;
    aStart = 1'b0;
    aReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      testsRun++;
      if ({aValid, aBusy, aDone} !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL abortIdle cycle%0d: got %b expected 000", k, {aValid, aBusy, aDone});
      end
      tick();
    end
    runFillA(0, "restartAfterAbort");
  endtask

  task automatic test_async_reset();
    logic [14:0] expVec;
    aStart = 1'b1;
    tick();
    aStart = 1'b0;
    aReady = 1'b1;
    for (int idx = 0; idx < 3; idx++) tick();
    expVec = {3'b110, AW'(3), expData(3, 0)};
    testsRun++;
    if ({aValid, aBusy, aDone, aAddr, aData} !== expVec) begin
      testsFailed++;
      $display("[TB] FAIL asyncPre: got %h expected %h", {aValid, aBusy, aDone, aAddr, aData}, expVec);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({aValid, aBusy, aDone, aAddr, aData} !== 15'h0) begin
      testsFailed++;
      $display("[TB] FAIL asyncReset: got %h expected %h", {aValid, aBusy, aDone, aAddr, aData}, 15'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      testsRun++;
      if ({aValid, aBusy, aDone, aAddr, aData} !== 15'h0) begin
        testsFailed++;
        $display("[TB] FAIL asyncStayIdle cycle%0d: got %h expected %h", k, {aValid, aBusy, aDone, aAddr, aData}, 15'h0);
      end
    end
    aReady = 1'b0;
  endtask

  task automatic test_step_shift();
    logic [14:0] expVec;
    bReady = 1'b1;
    bStart = 1'b1;
    tick();
    bStart = 1'b0;
    for (int idx = 0; idx < DB; idx++) begin
      expVec = {3'b110, AW'(idx), expData(idx, 1)};
      testsRun++;
      if ({bValid, bBusy, bDone, bAddr, bData} !== expVec) begin
        testsFailed++;
        $display("[TB] FAIL stepShift word%0d: got %h expected %h", idx, {bValid, bBusy, bDone, bAddr, bData}, expVec);
      end
      tick();
    end
    bReady = 1'b0;
    testsRun++;
    if ({bValid, bBusy, bDone} !== 3'b011) begin
      testsFailed++;
      $display("[TB] FAIL stepShiftDone: got %b expected 011", {bValid, bBusy, bDone});
    end
    tick();
    testsRun++;
    if ({bValid, bBusy, bDone} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL stepShiftIdle: got %b expected 000", {bValid, bBusy, bDone});
    end
  endtask

  task automatic test_depth_one();
    logic [13:0] expVec;
    cStart = 1'b1;
    tick();
    cStart = 1'b0;
    expVec = {3'b110, CW'(0), expData(0, 0)};
    for (int k = 0; k < 2; k++) begin
      testsRun++;
      if ({cValid, cBusy, cDone, cAddr, cData} !== expVec) begin
        testsFailed++;
        $display("[TB] FAIL depthOneWord cycle%0d: got %h expected %h", k, {cValid, cBusy, cDone, cAddr, cData}, expVec);
      end
      cReady = (k == 1);
      tick();
    end
    cReady = 1'b0;
    testsRun++;
    if ({cValid, cBusy, cDone} !== 3'b011) begin
      testsFailed++;
      $display("[TB] FAIL depthOneDone: got %b expected 011", {cValid, cBusy, cDone});
    end
    tick();
    testsRun++;
    if ({cValid, cBusy, cDone} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL depthOneIdle: got %b expected 000", {cValid, cBusy, cDone});
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_random_fill();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_step_shift();
    test_depth_one();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
